// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
// Holds width defaults, the complex sample type, bitrev() and the read FSM states.
package fft_pkg;

   localparam int FFT_DATA_W = 24;
   localparam int FFT_LOG2N  = 4;

   typedef struct packed {
      logic signed [FFT_DATA_W-1:0] re;
      logic signed [FFT_DATA_W-1:0] im;
   } cplx_t;

   typedef enum logic {
      R_IDLE,
      R_DRAIN
   } rstate_e;

   // Reverse the low lg bits of idx; upper bits come back as zero.
   function automatic logic [15:0] bitrev(input logic [15:0] idx,
                                          input int          lg);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < lg; i++) begin
         r[i] = idx[lg-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One reorder bank: simple dual-port RAM, one write port, one registered read port.
// Ports: clk, reset, we_i/waddr_i/wdata_i (write), re_i/raddr_i (read), rdata_o (1-cycle latency).
module fft_reorder_bank
   import fft_pkg::*;
#(
   parameter int AW = FFT_LOG2N,
   parameter int W  = 2 * FFT_DATA_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [2**AW];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read register only advances on re_i, so it doubles as the held output.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversal reorder buffer: bit-reversed input frames out in natural order via ping-pong banks.
// Ports: clk, reset, in_valid/in_ready/din_r/din_i, out_valid/out_ready/dout_r/dout_i[, out_last with FFT_REORDER_LAST_EN].
module fft_reorder
   import fft_pkg::*;
#(
   parameter int LOG2N  = FFT_LOG2N,
   parameter int DATA_W = FFT_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] din_r,
   input  logic [DATA_W-1:0] din_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] dout_r,
   output logic [DATA_W-1:0] dout_i
`ifdef FFT_REORDER_LAST_EN
   ,
   output logic              out_last
`endif
);

   localparam int N  = 1 << LOG2N;
   localparam int W2 = 2 * DATA_W;

   typedef logic [LOG2N-1:0] addr_t;

   logic    wsel_q;
   logic    rsel_q;
   logic    osel_q;
   addr_t   wcnt_q;
   addr_t   rcnt_q;
   logic [1:0] full_q;
   logic [1:0] full_d;
   rstate_e state_q;
   logic    ov_q;
`ifdef FFT_REORDER_LAST_EN
   logic    last_q;
`endif

   logic    wr_fire;
   logic    wr_last;
   addr_t   wr_addr;
   logic    adv;
   logic    rd_fire;
   logic    rd_last;
   logic [W2-1:0] rdata [2];
   logic [W2-1:0] dout;

   assign in_ready = !full_q[wsel_q];
   assign wr_fire  = in_valid && in_ready;
   assign wr_last  = wr_fire && (wcnt_q == addr_t'(N-1));
   assign wr_addr  = addr_t'(bitrev(16'(wcnt_q), LOG2N));

   // Output stage may take a new word when empty or being consumed.
   assign adv     = !ov_q || out_ready;
   // Idle with a full bank reads address 0 at once; no wasted cycle.
   assign rd_fire = adv && ((state_q == R_DRAIN) || full_q[rsel_q]);
   assign rd_last = rd_fire && (rcnt_q == addr_t'(N-1));

   // Write and read sides always own different banks here.
   always_comb begin
      full_d = full_q;
      if (wr_last) full_d[wsel_q] = 1'b1;
      if (rd_last) full_d[rsel_q] = 1'b0;
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_reorder_bank #(
         .AW (LOG2N),
         .W  (W2)
      ) u_bank (
         .clk     (clk),
         .reset   (reset),
         .we_i    (wr_fire && (wsel_q == 1'(b))),
         .waddr_i (wr_addr),
         .wdata_i ({din_r, din_i}),
         .re_i    (rd_fire && (rsel_q == 1'(b))),
         .raddr_i (rcnt_q),
         .rdata_o (rdata[b])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wsel_q  <= 1'b0;
         rsel_q  <= 1'b0;
         osel_q  <= 1'b0;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         full_q  <= '0;
         state_q <= R_IDLE;
         ov_q    <= 1'b0;
`ifdef FFT_REORDER_LAST_EN
         last_q  <= 1'b0;
`endif
      end else begin
         full_q <= full_d;
         if (wr_fire) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (wr_last) wsel_q <= ~wsel_q;
         end
         if (adv) begin
            ov_q <= rd_fire;
`ifdef FFT_REORDER_LAST_EN
            last_q <= rd_last;
`endif
         end
         if (rd_fire) begin
            osel_q <= rsel_q;
            rcnt_q <= rcnt_q + 1'b1;
            if (rd_last) begin
               rsel_q  <= ~rsel_q;
               state_q <= full_q[~rsel_q] ? R_DRAIN : R_IDLE;
            end else begin
               state_q <= R_DRAIN;
            end
         end
      end
   end

   assign dout      = rdata[osel_q];
   assign dout_r    = dout[W2-1:DATA_W];
   assign dout_i    = dout[DATA_W-1:0];
   assign out_valid = ov_q;
`ifdef FFT_REORDER_LAST_EN
   assign out_last  = last_q;
`endif

endmodule

// File: doc/fft_reorder.md
# fft_reorder

Bit-reversal reorder buffer at the output of the radix-2 SDF FFT pipeline. It accepts complex 24-bit samples in the pipeline's bit-reversed arrival order and emits them in natural frequency order. It uses a ping-pong pair of N-entry banks so that one frame can be written while the previous frame is read. It sits between the last butterfly/delay-line stage and the accelerator's result interface.

## Interface
- LOG2N, 4: log2 of frame length; N = 2**LOG2N (16-point default).
- DATA_W, 24: width of each real/imag component, signed two's complement.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all control state.
- in_valid  in  1  input sample present.
- in_ready  out  1  buffer can accept a sample this cycle.
- din_r  in  DATA_W  real part, bit-reversed order.
- din_i  in  DATA_W  imaginary part.
- out_valid  out  1  dout_r/dout_i hold a valid natural-order sample.
- out_ready  in  1  downstream accepts the sample this cycle.
- dout_r  out  DATA_W  real part, natural order.
- dout_i  out  DATA_W  imaginary part.
- out_last  out  1  final sample of a frame (present only with FFT_REORDER_LAST_EN).

## Operation
- Input transfer happens when in_valid && in_ready; output transfer happens when out_valid && out_ready.
- Write side: wsel selects the bank and wcnt (LOG2N bits) counts arrivals. Each sample is stored at address bitrev(wcnt). On the N-th write, full[wsel] is set, wsel toggles and wcnt wraps to 0.
- in_ready = !full[wsel]. Input is stalled only when both banks hold undrained frames.
- Read side FSM:
  - R_IDLE: waits for full[rsel].
  - R_DRAIN: reads address rcnt sequentially from 0 to N-1. After the read of address N-1, it clears full[rsel], toggles rsel and returns to R_IDLE. If the other bank is already full, it re-enters R_DRAIN with no bubble.
- Output register: dout/out_valid form a single skid-free register stage. The RAM read is advanced only when the register is empty or being consumed (!out_valid || out_ready). While out_ready is low, dout holds stable.
- Data passes through unmodified; there is no arithmetic, rounding or sign change.
- Simultaneous events: a frame completing on the write side in the same cycle the read side drains the last word of the other bank is legal. full set and clear target different banks and both take effect.
- Reset mid-frame: all partial and complete frames are discarded. wsel=rsel=0, wcnt=rcnt=0, full=0, FSM=R_IDLE.
- Unconsumed in_valid while in_ready=0 is held by the upstream; no data is dropped.

## Timing
- Reset values: in_ready=1, out_valid=0, dout_r=0, dout_i=0, out_last=0.
- Latency: last sample of a frame accepted in cycle t gives the first output with out_valid=1 in cycle t+2.
- Throughput: with out_ready held high, N outputs are produced on consecutive cycles. Back-to-back frames stream at 1 sample/cycle sustained.
- in_ready is a function of registered state only; there is no combinational path from out_ready.
- Bank RAM: 1 write port and 1 synchronous read port, one-cycle read latency.

## Configuration
- FFT_REORDER_LAST_EN defined: the out_last port exists and is high together with out_valid on the output of natural index N-1. It resets to 0 and holds with dout under backpressure.
- FFT_REORDER_LAST_EN undefined: the port and its logic are absent. Framing is implied by counting N outputs.

## Structure
- Shared package fft_pkg:
  - DATA_W and LOG2N defaults.
  - typedef cplx_t (struct of signed re/im).
  - function bitrev(idx, LOG2N).
  - read FSM state enum.
- Sub-module fft_reorder_bank: N×(2·DATA_W) simple dual-port RAM, synchronous read, instantiated twice.

## Test plan
- Single frame, N=16: feed din_r=bitrev4(k), din_i=-bitrev4(k) for k=0..15, i.e. 0,8,4,12,2,10,… Expected: dout_r=0,1,…,15 and dout_i=0,-1,…,-15 on consecutive cycles. First out_valid arrives 2 cycles after the 16th input. out_last is high only on 15 (with macro).
- Continuous three frames with frame f offset by 100·f: 48 ordered outputs with no gaps after the initial latency. in_ready stays high.
- Backpressure: out_ready=0 for 40 cycles during frame 0. Two frames are accepted, then in_ready=0 on the 33rd input. dout holds value 0 stable throughout. On release, order is preserved and no samples are lost.
- Random out_ready (50%) over 10 frames: the scoreboard matches the natural-order reference exactly.
- Reset asserted after 7 inputs of frame 1 while frame 0 is draining: next cycle out_valid=0 and in_ready=1. A fresh frame afterwards outputs 0..15 correctly.
- Extreme values: din_r=0x7FFFFF and din_i=0x800000 at arrival k=1 (natural index 8) are output unchanged at position 8.
